// File: rtl/dec_rr_arbiter8.sv
// Round-robin arbiter for one 8-way decoded resource: registered index/enable,
// decoded one-hot grant, bounded grant length and a mandatory idle gap per grant.
module dec_rr_arbiter8 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] R,
    output logic [2:0] W,
    output logic       En,
    output logic [7:0] G,
    output logic       Expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [2:0]       w_q, w_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       g_q, g_d;
    logic             expired_q, expired_d;

    // scan_idx[k] is the k-th candidate after the last served index; the
    // final entry wraps back onto last_q so a lone requester is re-served.
    logic [2:0] scan_idx [8];
    logic [7:0] scan_req;
    logic [2:0] pick;
    logic       found;

    for (genvar gi = 0; gi < 8; gi++) begin : g_scan
        assign scan_idx[gi] = last_q + 3'(gi + 1);
        assign scan_req[gi] = R[scan_idx[gi]];
    end

    always_comb begin
        pick  = last_q;
        found = |scan_req;
        for (int k = 7; k >= 0; k--) begin
            if (scan_req[k]) pick = scan_idx[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        expired_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                g_d   = '0;
                if (found) begin
                    state_d = GRANT;
                    w_d     = pick;
                    last_d  = pick;
                    cnt_d   = CNT_W'(1);
                    g_d     = 8'(1) << pick;
                end
            end
            GRANT: begin
                // Release wins over timeout, so Expired stays low on a release.
                if (!R[w_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    g_d     = '0;
                end else if (cnt_q < HOLD_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    g_d       = '0;
                    expired_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                g_d     = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            w_q       <= 3'd0;
            last_q    <= 3'd7;
            cnt_q     <= '0;
            g_q       <= 8'd0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            g_q       <= g_d;
            expired_q <= expired_d;
        end
    end

    assign W       = w_q;
    assign En      = (state_q == GRANT);
    assign G       = g_q;
    assign Expired = expired_q;

endmodule

// File: tb/tb_dec_rr_arbiter8.sv
// Scoreboard bench for dec_rr_arbiter8: directed grants are queued as expected
// (index, length, expired) records and checked by a monitor when each grant ends.
module tb_dec_rr_arbiter8;

    localparam int HOLD = 4;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] R      = 8'd0;
    logic [2:0] W;
    logic       En;
    logic [7:0] G;
    logic       Expired;

    always #5 Clock = ~Clock;

    dec_rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .R       (R),
        .W       (W),
        .En      (En),
        .G       (G),
        .Expired (Expired)
    );

    typedef struct {
        logic [2:0] w;
        int         len;
        logic       expd;
    } grant_t;

    grant_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     random_mode = 1'b0;
    bit     end_req = 1'b0;
    bit     end_ack = 1'b0;

    logic       en_prev = 1'b0;
    logic [2:0] w_prev  = 3'd0;
    int         run_len = 0;
    logic [7:0] g_exp;
    bit         inv_ok;
    grant_t     cur;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [2:0] w, input int len, input logic e);
        grant_t t;
        t.w = w; t.len = len; t.expd = e;
        exp_q.push_back(t);
    endtask

    // Monitor: reset checks on Resetn fall, invariants every cycle, and a
    // scoreboard pop whenever a grant ends (En falls).
    always begin
        @(negedge Clock or negedge Resetn);
        if (!Resetn) begin
            #1;
            checks++;
            if (En !== 1'b0 || G !== 8'd0 || W !== 3'd0 || Expired !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: En=%b W=%0d G=%h Expired=%b, required En=0 W=0 G=00 Expired=0",
                         En, W, G, Expired);
            end
            en_prev = 1'b0;
            w_prev  = 3'd0;
            run_len = 0;
        end else begin
            if (En === 1'b1) run_len = en_prev ? run_len + 1 : 1;
            g_exp  = (En === 1'b1) ? (8'b1 << W) : 8'd0;
            inv_ok = (G === g_exp)
                  && (En === 1'b1 || En === 1'b0)
                  && !(Expired === 1'b1 && !(en_prev && En === 1'b0))
                  && ((En === 1'b1 && !en_prev) || W === w_prev)
                  && (run_len <= HOLD);
            checks++;
            if (!inv_ok) begin
                errors++;
                $display("FAIL invariant: En=%b W=%0d G=%h Expired=%b run=%0d, required G=%h, W stable, Expired only on grant end, run<=%0d",
                         En, W, G, Expired, run_len, g_exp, HOLD);
            end
            if (en_prev && En === 1'b0 && !random_mode) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: W=%0d len=%0d Expired=%b, required no grant",
                             w_prev, run_len, Expired);
                end else begin
                    cur = exp_q.pop_front();
                    if (w_prev !== cur.w || run_len != cur.len || Expired !== cur.expd) begin
                        errors++;
                        $display("FAIL grant: W=%0d len=%0d Expired=%b, required W=%0d len=%0d Expired=%b",
                                 w_prev, run_len, Expired, cur.w, cur.len, cur.expd);
                    end else begin
                        $display("grant W=%0d len=%0d Expired=%b ok", w_prev, run_len, Expired);
                    end
                end
            end
            en_prev = (En === 1'b1);
            w_prev  = W;
            if (end_req && !end_ack) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_grants: %0d expected grants never seen, required 0", exp_q.size());
                end
                end_ack = 1'b1;
            end
        end
    end

    initial begin
        Resetn = 1'b0;
        R      = 8'd0;
        tick(3);
        Resetn = 1'b1;
        tick(2);

        // Single requester times out repeatedly, re-granted after each gap
        push(3'd2, HOLD, 1'b1);
        push(3'd2, HOLD, 1'b1);
        R = 8'b0000_0100;
        tick(2 * (HOLD + 1));
        R = 8'd0;
        tick(3);

        // Fresh reset: index 0 first, then full rotation with wrap
        Resetn = 1'b0;
        tick(2);
        Resetn = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) push(3'(i), HOLD, 1'b1);
        push(3'd0, HOLD, 1'b1);
        R = 8'hFF;
        tick(9 * (HOLD + 1));
        R = 8'd0;
        tick(3);

        // Voluntary release after 3 cycles
        push(3'd3, 3, 1'b0);
        R = 8'b0000_1000;
        tick(3);
        R = 8'd0;
        tick(3);

        // Release on the very cycle the timeout would fire: no Expired
        push(3'd4, HOLD, 1'b0);
        R = 8'b0001_0000;
        tick(HOLD);
        R = 8'd0;
        tick(3);

        // Last=6, then scan order starts at 7 and wraps to 0
        push(3'd6, 1, 1'b0);
        R = 8'b0100_0000;
        tick(1);
        R = 8'd0;
        tick(2);
        push(3'd0, HOLD, 1'b1);
        push(3'd1, HOLD, 1'b1);
        push(3'd6, HOLD, 1'b1);
        R = 8'b0100_0011;
        tick(3 * (HOLD + 1));
        R = 8'd0;
        tick(3);

        // Asynchronous reset mid-grant, then a full grant restarting at Cnt=1
        R = 8'b0010_0000;
        tick(2);
        #1 Resetn = 1'b0;
        #2 Resetn = 1'b1;
        push(3'd5, HOLD, 1'b1);
        tick(HOLD + 1);
        R = 8'd0;
        tick(3);

        // Random traffic: invariants only
        random_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            R = 8'($urandom);
            tick(int'($urandom_range(1, 8)));
        end
        R = 8'd0;
        tick(3);

        end_req = 1'b1;
        for (int i = 0; i < 20 && !end_ack; i++) @(posedge Clock);
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor never acknowledged, required acknowledge");
            $fatal(1, "monitor stalled");
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
